// File: rtl/cache_fill_ctrl.sv
// Miss-handling controller: probes a direct-mapped cache, refills a missing line word by word
// from main memory, writes it with one fill cycle, then returns the addressed word.
module cache_fill_ctrl #(
  parameter int unsigned WORDS      = 16,
  parameter int unsigned SIZE       = 32,
  parameter int unsigned BLOCK_SIZE = WORDS * SIZE,
  parameter int unsigned CNT_W      = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  cpu_req,
  input  logic [31:0]           cpu_addr,
  output logic                  cpu_busy,
  output logic                  cpu_ready,
  output logic [SIZE-1:0]       cpu_data,
  output logic [31:0]           cache_address,
  output logic                  cache_read,
  output logic [BLOCK_SIZE-1:0] cache_dataIn,
  input  logic                  cache_hit,
  input  logic [SIZE-1:0]       cache_dataOut,
  output logic                  mem_req,
  output logic [31:0]           mem_addr,
  input  logic                  mem_ack,
  input  logic [SIZE-1:0]       mem_rdata,
  output logic [CNT_W-1:0]      hit_count,
  output logic [CNT_W-1:0]      miss_count
);

  localparam int unsigned OffW = $clog2(WORDS);

  typedef enum logic [2:0] {
    StIdle,
    StLookup,
    StCheck,
    StFetch,
    StFill,
    StRespond
  } state_e;

  state_e          state_q;
  logic [OffW-1:0] count_q;

  assign cpu_busy = (state_q != StIdle);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= StIdle;
      count_q       <= '0;
      cpu_ready     <= 1'b0;
      cpu_data      <= '0;
      cache_address <= '0;
      cache_read    <= 1'b1;
      cache_dataIn  <= '0;
      mem_req       <= 1'b0;
      mem_addr      <= '0;
      hit_count     <= '0;
      miss_count    <= '0;
    end else begin
      cpu_ready <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (cpu_req) begin
            cache_address <= cpu_addr;
            state_q       <= StLookup;
          end
        end
        StLookup: state_q <= StCheck;
        StCheck: begin
          if (cache_hit) begin
            cpu_data  <= cache_dataOut;
            cpu_ready <= 1'b1;
            if (hit_count != '1) hit_count <= hit_count + CNT_W'(1);
            state_q   <= StIdle;
          end else begin
            if (miss_count != '1) miss_count <= miss_count + CNT_W'(1);
            count_q  <= '0;
            mem_req  <= 1'b1;
            mem_addr <= {cache_address[31:OffW], {OffW{1'b0}}};
            state_q  <= StFetch;
          end
        end
        StFetch: begin
          // mem_req/mem_addr hold until an ack; each ack lands one word of the line.
          if (mem_ack) begin
            cache_dataIn[SIZE*count_q +: SIZE] <= mem_rdata;
            if (count_q == OffW'(WORDS - 1)) begin
              mem_req    <= 1'b0;
              cache_read <= 1'b0;
              state_q    <= StFill;
            end else begin
              count_q  <= count_q + OffW'(1);
              mem_addr <= {cache_address[31:OffW], count_q + OffW'(1)};
            end
          end
        end
        StFill: begin
          cache_read <= 1'b1;
          state_q    <= StRespond;
        end
        StRespond: begin
          // The cache drops hit on a fill, so the word is taken unconditionally.
          cpu_data  <= cache_dataOut;
          cpu_ready <= 1'b1;
          state_q   <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_cache_fill_ctrl.sv
// Directed bench for cache_fill_ctrl with a behavioural direct-mapped cache and main memory.
module tb_cache_fill_ctrl;

  logic         clk = 1'b0;
  logic         reset;
  logic         cpu_req;
  logic [31:0]  cpu_addr;
  logic         cpu_busy, cpu_ready;
  logic [31:0]  cpu_data;
  logic [31:0]  cache_address;
  logic         cache_read;
  logic [511:0] cache_dataIn;
  logic         cache_hit = 1'b0;
  logic [31:0]  cache_dataOut = '0;
  logic         mem_req;
  logic [31:0]  mem_addr;
  logic         mem_ack;
  logic [31:0]  mem_rdata;
  logic [15:0]  hit_count, miss_count;

  // Narrow-counter instance that loops on hits to reach saturation quickly.
  logic         s_busy, s_ready, s_cread, s_mreq;
  logic [31:0]  s_data, s_caddr, s_maddr;
  logic [511:0] s_line;
  logic [3:0]   s_hits, s_misses;

  int vectors = 0;
  int miscompares = 0;

  logic [31:0] mem_base = 32'hA000_0000;
  bit          wait_mode = 1'b0;
  int          wcnt = 0;

  bit          cvalid [256];
  bit   [19:0] ctag   [256];
  bit   [31:0] cmem   [256][16];

  logic [31:0]  beat_q[$];
  int           fill_cycles = 0;
  logic [511:0] fill_line = '0;
  int           addr_jumps = 0;
  logic         mon_req = 1'b0, mon_ack = 1'b0;
  logic [31:0]  mon_addr = '0;

  cache_fill_ctrl dut (
    .clk(clk), .reset(reset), .cpu_req(cpu_req), .cpu_addr(cpu_addr),
    .cpu_busy(cpu_busy), .cpu_ready(cpu_ready), .cpu_data(cpu_data),
    .cache_address(cache_address), .cache_read(cache_read), .cache_dataIn(cache_dataIn),
    .cache_hit(cache_hit), .cache_dataOut(cache_dataOut),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .hit_count(hit_count), .miss_count(miss_count)
  );

  cache_fill_ctrl #(.CNT_W(4)) sat_dut (
    .clk(clk), .reset(reset), .cpu_req(1'b1), .cpu_addr(32'h0000_0040),
    .cpu_busy(s_busy), .cpu_ready(s_ready), .cpu_data(s_data),
    .cache_address(s_caddr), .cache_read(s_cread), .cache_dataIn(s_line),
    .cache_hit(1'b1), .cache_dataOut(32'h1234_5678),
    .mem_req(s_mreq), .mem_addr(s_maddr), .mem_ack(1'b0), .mem_rdata(32'h0),
    .hit_count(s_hits), .miss_count(s_misses)
  );

  always #5 clk = ~clk;

  // Memory: word i of a block reads as mem_base + i; in wait mode ack every third cycle.
  assign mem_rdata = mem_base + {28'd0, mem_addr[3:0]};
  assign mem_ack   = wait_mode ? (mem_req && wcnt == 2) : 1'b1;

  always @(posedge clk) wcnt <= (!mem_req || wcnt == 2) ? 0 : wcnt + 1;

  always @(posedge clk) begin
    if (cache_read) begin
      cache_hit     <= cvalid[cache_address[11:4]] && ctag[cache_address[11:4]] == cache_address[31:12];
      cache_dataOut <= cmem[cache_address[11:4]][cache_address[3:0]];
    end else begin
      cvalid[cache_address[11:4]] <= 1'b1;
      ctag[cache_address[11:4]]   <= cache_address[31:12];
      for (int i = 0; i < 16; i++) cmem[cache_address[11:4]][i] <= cache_dataIn[32*i +: 32];
      cache_hit     <= 1'b0;
      cache_dataOut <= cache_dataIn[32*cache_address[3:0] +: 32];
    end
  end

  always @(posedge clk) begin
    if (mem_req && mem_ack) beat_q.push_back(mem_addr);
    if (!cache_read) begin
      fill_cycles <= fill_cycles + 1;
      fill_line   <= cache_dataIn;
    end
  end

  always @(negedge clk) begin
    if (mon_req && !mon_ack && mem_req && mem_addr !== mon_addr) addr_jumps <= addr_jumps + 1;
    mon_req  <= mem_req;
    mon_ack  <= mem_ack;
    mon_addr <= mem_addr;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Issue one request at the next edge; lat counts negedges until cpu_ready is seen.
  task automatic do_req(input logic [31:0] addr, input bit pulse, output int lat);
    cpu_addr = addr;
    cpu_req  = 1'b1;
    @(posedge clk);
    #1 cpu_req = 1'b0;
    lat = 0;
    while (lat < 200) begin
      @(negedge clk);
      lat++;
      if (cpu_ready) break;
      if (pulse && lat % 4 == 0 && lat < 40) begin
        chk("busy_during_fetch", {31'd0, cpu_busy}, 32'd1);
        cpu_req  = 1'b1;
        cpu_addr = 32'hFFFF_FFF0;
      end else begin
        cpu_req = 1'b0;
      end
    end
    cpu_req = 1'b0;
  endtask

  task automatic do_miss(input logic [31:0] addr, input logic [31:0] base, input bit wmode,
                         input bit pulse, input int exp_lat, input int exp_miss);
    int lat, q0, f0, j0;
    mem_base  = base;
    wait_mode = wmode;
    q0 = beat_q.size();
    f0 = fill_cycles;
    j0 = addr_jumps;
    do_req(addr, pulse, lat);
    chk("miss_latency", lat, exp_lat);
    chk("miss_beats", beat_q.size() - q0, 16);
    chk("fill_cycles", fill_cycles - f0, 1);
    chk("addr_stable", addr_jumps - j0, 0);
    for (int i = 0; i < 16 && q0 + i < beat_q.size(); i++) begin
      chk("beat_addr", beat_q[q0+i], {addr[31:4], 4'(i)});
      chk("line_word", fill_line[32*i +: 32], base + i);
    end
    chk("miss_data", cpu_data, base + {28'd0, addr[3:0]});
    chk("miss_count", {16'd0, miss_count}, exp_miss);
    wait_mode = 1'b0;
  endtask

  initial begin
    int lat, q0, f0;
    reset    = 1'b1;
    cpu_req  = 1'b0;
    cpu_addr = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", {31'd0, cpu_busy}, 0);
    chk("rst_ready", {31'd0, cpu_ready}, 0);
    chk("rst_data", cpu_data, 0);
    chk("rst_caddr", cache_address, 0);
    chk("rst_cread", {31'd0, cache_read}, 1);
    chk("rst_line_zero", {31'd0, cache_dataIn == '0}, 1);
    chk("rst_mreq", {31'd0, mem_req}, 0);
    chk("rst_maddr", mem_addr, 0);
    chk("rst_hits", {16'd0, hit_count}, 0);
    chk("rst_misses", {16'd0, miss_count}, 0);
    reset = 1'b0;

    // Cold miss, then hit, then a back-to-back hit accepted as cpu_ready ends.
    do_miss(32'h0000_1234, 32'hA000_0000, 1'b0, 1'b0, 21, 1);
    chk("cold_hits", {16'd0, hit_count}, 0);
    q0 = beat_q.size();
    do_req(32'h0000_1239, 1'b0, lat);
    chk("hit_latency", lat, 3);
    chk("hit_data", cpu_data, 32'hA000_0009);
    chk("hit_count", {16'd0, hit_count}, 1);
    chk("hit_no_beats", beat_q.size() - q0, 0);
    do_req(32'h0000_1234, 1'b0, lat);
    chk("b2b_latency", lat, 3);
    chk("b2b_data", cpu_data, 32'hA000_0004);
    chk("b2b_hits", {16'd0, hit_count}, 2);

    // Conflict misses on index 0x23.
    do_miss(32'h0000_2234, 32'hB000_0000, 1'b0, 1'b0, 21, 2);
    do_miss(32'h0000_1234, 32'hA000_0000, 1'b0, 1'b0, 21, 3);

    // Wait states with ignored cpu_req pulses while busy.
    do_miss(32'h0000_3456, 32'hD000_0000, 1'b1, 1'b1, 53, 4);
    repeat (3) @(negedge clk);
    chk("idle_after_pulses", {31'd0, cpu_busy}, 0);
    chk("pulses_not_queued", {16'd0, miss_count}, 4);
    chk("hits_after_wait", {16'd0, hit_count}, 2);
    chk("sat_hits_pre", {28'd0, s_hits}, 32'hF);

    // Reset after word 7 of a fetch.
    mem_base = 32'hC000_0000;
    q0 = beat_q.size();
    f0 = fill_cycles;
    cpu_addr = 32'h0000_5678;
    cpu_req  = 1'b1;
    @(posedge clk);
    #1 cpu_req = 1'b0;
    lat = 0;
    while (beat_q.size() - q0 < 8 && lat < 50) begin
      @(negedge clk);
      lat++;
    end
    chk("beats_before_reset", beat_q.size() - q0, 8);
    reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    chk("rst_fetch_mreq", {31'd0, mem_req}, 0);
    chk("rst_fetch_cread", {31'd0, cache_read}, 1);
    chk("rst_fetch_busy", {31'd0, cpu_busy}, 0);
    chk("rst_fetch_line", {31'd0, cache_dataIn == '0}, 1);
    chk("rst_fetch_misses", {16'd0, miss_count}, 0);
    chk("rst_fetch_hits", {16'd0, hit_count}, 0);
    chk("sat_hits_cleared", {28'd0, s_hits}, 0);
    @(negedge clk);
    chk("rst_no_fill", fill_cycles - f0, 0);
    do_miss(32'h0000_5678, 32'hC000_0000, 1'b0, 1'b0, 21, 1);

    // Narrow instance has had well over 15 hits since the last reset.
    repeat (30) @(negedge clk);
    chk("sat_hits", {28'd0, s_hits}, 32'hF);
    chk("sat_misses", {28'd0, s_misses}, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
